// File: rtl/btn_pkg.sv
// Shared types and default constants for the button edge conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StHeld        = 2'd2,
    StReleaseWait = 2'd3
  } btn_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned REPEAT_CYCLES_DEF   = 25000000;

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low reset.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/btn_edge_conditioner.sv
// Synchronise, debounce and edge-detect a push-button; snapshot switches on each press.
// Optional auto-repeat of press_pulse while held is enabled by defining BTN_AUTOREPEAT_EN.
module btn_edge_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SW_WIDTH        = 4,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic                btn_level,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic [SW_WIDTH-1:0] sw_snap
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  logic                btn_s;
  logic [SW_WIDTH-1:0] sw_s;

  sync2 #(.WIDTH(1)) u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_s)
  );

  sync2 #(.WIDTH(SW_WIDTH)) u_sync_sw (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_raw),
    .q     (sw_s)
  );

  btn_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic [SW_WIDTH-1:0] snap_q, snap_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
  logic [RepW-1:0] rep_q, rep_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      snap_q    <= snap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    snap_d    = snap_q;
`ifdef BTN_AUTOREPEAT_EN
    rep_d     = rep_q;
`endif
    case (state_q)
      StIdle: begin
        if (btn_s) begin
          cnt_d   = '0;
          state_d = StPressWait;
        end
      end
      StPressWait: begin
        if (!btn_s) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StHeld;
          press_d = 1'b1;
          level_d = 1'b1;
          snap_d  = sw_s;
`ifdef BTN_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end else if (cnt_q < CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!btn_s) begin
          cnt_d   = '0;
          state_d = StReleaseWait;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rep_q == RepLast) begin
          press_d = 1'b1;
          snap_d  = sw_s;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
`endif
      end
      StReleaseWait: begin
        // A bounce back to Held keeps the repeat phase; only an accepted release clears it.
        if (btn_s) begin
          state_d = StHeld;
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          release_d = 1'b1;
          level_d   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
          rep_d     = '0;
`endif
        end else if (cnt_q < CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign sw_snap       = snap_q;

endmodule

// File: tb/tb_btn_edge_conditioner.sv
// Randomised and directed bench for btn_edge_conditioner against a run-length reference model.
module tb_btn_edge_conditioner;

  localparam int unsigned Deb = 8;
  localparam int unsigned Rep = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic [3:0] sw_raw = 4'd0;
  logic       btn_level, press_pulse, release_pulse;
  logic [3:0] sw_snap;

  btn_edge_conditioner #(
    .DEBOUNCE_CYCLES (Deb),
    .SW_WIDTH        (4),
    .REPEAT_CYCLES   (Rep)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_raw       (btn_raw),
    .sw_raw        (sw_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .sw_snap       (sw_snap)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: inputs are seen two edges late; a new level is accepted once the
  // synchronised input has disagreed with the accepted level for Deb+1 edges in a row.
  logic [1:0] m_bdly;
  logic [3:0] m_sdly [2];
  logic       m_level, m_press, m_rel;
  logic [3:0] m_snap;
  int         m_run, m_rep;

  task automatic model_reset();
    m_bdly = 2'b00; m_sdly[0] = 4'd0; m_sdly[1] = 4'd0;
    m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_snap = 4'd0;
    m_run = 0; m_rep = 0;
  endtask

  task automatic model_step(input logic b, input logic [3:0] s);
    logic bs;
    logic [3:0] ss;
    bit bounced;
    bs = m_bdly[1];
    ss = m_sdly[1];
    m_press = 1'b0;
    m_rel = 1'b0;
    if (bs != m_level) begin
      m_run++;
      if (m_run == Deb + 1) begin
        m_level = bs;
        m_run = 0;
        m_rep = 0;
        if (bs) begin
          m_press = 1'b1;
          m_snap = ss;
        end else begin
          m_rel = 1'b1;
        end
      end
    end else begin
      bounced = (m_run != 0);
      m_run = 0;
`ifdef BTN_AUTOREPEAT_EN
      if (m_level && !bounced) begin
        m_rep++;
        if (m_rep == Rep) begin
          m_rep = 0;
          m_press = 1'b1;
          m_snap = ss;
        end
      end
`else
      if (bounced) m_rep = 0;
`endif
    end
    m_bdly = {m_bdly[0], b};
    m_sdly[1] = m_sdly[0];
    m_sdly[0] = s;
  endtask

  task automatic compare_all();
    check("level", btn_level, m_level);
    check("press", press_pulse, m_press);
    check("release", release_pulse, m_rel);
    check("snap", sw_snap, m_snap);
    check("strobe_excl", press_pulse & release_pulse, 1'b0);
  endtask

  // Called at posedge+1; drives inputs, advances one edge, then compares.
  task automatic cycle(input logic b, input logic [3:0] s);
    btn_raw = b;
    sw_raw = s;
    @(posedge clk);
    model_step(b, s);
    #1;
    compare_all();
  endtask

  int first_press, n_press, n_rel;

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check("rst_level", btn_level, 1'b0);
    check("rst_press", press_pulse, 1'b0);
    check("rst_release", release_pulse, 1'b0);
    check("rst_snap", sw_snap, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'd0);

    // Clean press
    first_press = -1; n_press = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b1, 4'b1010);
      if (press_pulse) begin
        n_press++;
        if (first_press < 0) first_press = i;
      end
    end
    check("clean_press_edge", first_press, 11);
    check("clean_press_count", n_press, 1);
    check("clean_level", btn_level, 1'b1);
    check("clean_snap", sw_snap, 4'b1010);

    // Release with switches changed while held
    n_rel = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 4'b0101);
      if (release_pulse) n_rel++;
    end
    check("release_count", n_rel, 1);
    check("release_snap", sw_snap, 4'b1010);
    check("release_level", btn_level, 1'b0);

    // Bounce rejection
    n_press = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin cycle(1'b1, 4'b0011); n_press += int'(press_pulse); end
      for (int i = 0; i < 2; i++) begin cycle(1'b0, 4'b0011); n_press += int'(press_pulse); end
    end
    for (int i = 0; i < 10; i++) begin cycle(1'b0, 4'b0011); n_press += int'(press_pulse); end
    check("bounce_press_count", n_press, 0);
    check("bounce_level", btn_level, 1'b0);

    // Reset while the debounce counter sits at 5
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'b1100);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_level", btn_level, 1'b0);
    check("midrst_press", press_pulse, 1'b0);
    check("midrst_release", release_pulse, 1'b0);
    check("midrst_snap", sw_snap, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrst_hold_press", press_pulse, 1'b0);
    rst_n = 1'b1;

    // Button held through reset release, then held 70 cycles past acceptance
    first_press = -1; n_press = 0;
    for (int i = 1; i <= 11 + 70; i++) begin
      cycle(1'b1, 4'b1100);
      if (press_pulse) begin
        n_press++;
        if (first_press < 0) first_press = i;
      end
    end
    check("postrst_press_edge", first_press, 11);
`ifdef BTN_AUTOREPEAT_EN
    check("hold_press_count", n_press, 4);
`else
    check("hold_press_count", n_press, 1);
`endif
    for (int i = 0; i < 14; i++) cycle(1'b0, 4'b1100);

    // Random bouncing segments
    for (int seg = 0; seg < 60; seg++) begin
      logic b;
      logic [3:0] s;
      int len;
      b = 1'($urandom_range(0, 1));
      s = 4'($urandom);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) s = 4'($urandom);
        cycle(b, s);
      end
    end
    for (int i = 0; i < 14; i++) cycle(1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
